// File: rtl/uart_echo_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_echo_fifo_if
// Byte handshake between the UART receiver/sender pair and the echo FIFO.
//   rx_data   : byte from the receiver, valid while rx_valid=1
//   rx_valid  : one-cycle strobe per received byte
//   tx_ready  : sender idle, may accept a byte
//   tx_data   : byte to the sender, held stable after tx_enable
//   tx_enable : one-cycle start strobe to the sender
// master = receiver/sender side (drives rx_* and tx_ready)
// slave  = echo FIFO (drives tx_data and tx_enable)
// ---------------------------------------------------------------------------
interface uart_echo_fifo_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_enable;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_enable
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_enable
  );
endinterface

// File: rtl/uart_echo_fifo.sv
// ---------------------------------------------------------------------------
// uart_echo_fifo
// Buffers bytes from a UART receiver in a DEPTH-entry FIFO and drains them to
// the UART sender whenever it is ready. Dropped bytes (FIFO full) raise a
// sticky overflow flag; count reports occupancy for debug LEDs.
//
// Ports:
//   CLK, RST_N    : clock, asynchronous active-low reset
//   bus (slave)   : rx_data/rx_valid in, tx_ready in, tx_data/tx_enable out
//   clr_overflow  : synchronous clear of overflow (a same-cycle drop wins)
//   overflow      : sticky, at least one byte was dropped
//   count         : FIFO occupancy, 0..DEPTH
//
// Optional feature: define UART_ECHO_UPCASE_EN to send 'a'..'z' as uppercase
// (DATA_W must be 8). Undefined: bytes are echoed verbatim.
// ---------------------------------------------------------------------------
module uart_echo_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  uart_echo_fifo_if.slave  bus,
  input  logic             clr_overflow,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_echo_fifo: DEPTH must be a power of two in 2..256");
  end

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty;
  logic              wr_en, drop, deq;
  logic [DATA_W-1:0] head;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Full is judged on the pre-edge count, so a same-cycle dequeue never
  // rescues an incoming byte.
  assign wr_en = bus.rx_valid && !full;
  assign drop  = bus.rx_valid && full;
  assign deq   = (state == IDLE) && !empty && bus.tx_ready;

`ifdef UART_ECHO_UPCASE_EN
  if (DATA_W != 8) begin : g_upcase_check
    $error("uart_echo_fifo: UART_ECHO_UPCASE_EN requires DATA_W == 8");
  end

  assign head = ((mem[rd_ptr] >= DATA_W'(8'h61)) && (mem[rd_ptr] <= DATA_W'(8'h7A)))
              ? mem[rd_ptr] - DATA_W'(8'h20)
              : mem[rd_ptr];
`else
  assign head = mem[rd_ptr];
`endif

  // ---------------- read FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------- read FSM: next state ----------------
  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (deq) state_nx = SEND;
      SEND:    state_nx = HOLD;
      HOLD:    state_nx = IDLE;   // guard cycle for the sender's tx_ready to fall
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- read FSM: outputs ----------------
  // Decoded from state, so an asynchronous reset drops the strobe at once.
  always_comb begin
    bus.tx_enable = (state == SEND);
  end

  // ---------------- storage ----------------
  // NOTE: the byte array is deliberately not reset; its contents are
  // don't-care once the pointers and count are cleared, and leaving it out of
  // the reset lets it map onto plain registers or RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= bus.rx_data;
  end

  // ---------------- pointers, occupancy, output byte, overflow ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      bus.tx_data <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);   // wraps DEPTH-1 -> 0

      if (deq) begin
        rd_ptr      <= rd_ptr + AW'(1);
        bus.tx_data <= head;
      end

      case ({wr_en, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule
